// File: rtl/vga_game_pkg.sv
// vga_game_pkg: shared button-conditioning types, button indices and 50 MHz timing defaults.
package vga_game_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DOWN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DOWN = 3;
    localparam int BTN_COUNT = BTN_P2_DOWN + 1;
    localparam int CLK_HZ = 50_000_000;
    localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;
    localparam int REPEAT_DELAY_DEFAULT = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, debounce FSM and press/release pulses for one button.
// Defining BTN_AUTOREPEAT_EN adds repeat press pulses while the button stays held.
module debounce_channel
    import vga_game_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic s;
    btn_state_t state;
    logic [CW-1:0] cnt;
    assign s = sync[SYNC_STAGES-1];
    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("debounce_channel: invalid parameters");
        end
    endgenerate
`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [RW-1:0] rc;
    logic [RW-1:0] rc_next;
    logic rep_first;
    assign rc_next = rc + RW'(1);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            state <= IDLE;
            cnt <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rc <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            press <= 1'b0;
            rel <= 1'b0;
            case (state)
                IDLE: if (s) begin
                    cnt <= '0;
                    state <= PRESS_WAIT;
                end
                PRESS_WAIT: if (!s) begin
                    cnt <= '0;
                    state <= IDLE;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    state <= HELD;
                    level <= 1'b1;
                    press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rc <= '0;
                    rep_first <= 1'b1;
`endif
                end else cnt <= cnt + CW'(1);
                HELD: if (!s) begin
                    cnt <= '0;
                    state <= RELEASE_WAIT;
                end
`ifdef BTN_AUTOREPEAT_EN
                // repeat counter only advances on cycles that stay in HELD
                else if (rc_next == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
                    press <= 1'b1;
                    rc <= '0;
                    rep_first <= 1'b0;
                end else rc <= rc_next;
`endif
                RELEASE_WAIT: if (s) begin
                    cnt <= '0;
                    state <= HELD;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    state <= IDLE;
                    level <= 1'b0;
                    rel <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rc <= '0;
                    rep_first <= 1'b1;
`endif
                end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: independent sync/debounce/edge-detect for each push-button channel.
// Defining BTN_AUTOREPEAT_EN enables auto-repeat press pulses; ports are unchanged.
module btn_conditioner
    import vga_game_pkg::*;
#(
    parameter int N_BTN = BTN_COUNT,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel(btn_release[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus against a run-length model of the debouncer.
module tb_btn_conditioner;
    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 8;
    localparam int RD = 20;
    localparam int RP = 5;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: a change is accepted once the synchronized input has differed from
    // the level on D+1 consecutive evaluations; repeats count cycles spent held.
    logic [N-1:0] hist [S];
    logic [N-1:0] m_level, m_press, m_rel;
    int run [N];
    int held_cnt [N];
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < S; j++) hist[j] = '0;
            m_level = '0;
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0;
                held_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic sv;
                logic staying_held;
                sv = hist[S-1][i];
                m_press[i] = 1'b0;
                m_rel[i] = 1'b0;
                staying_held = m_level[i] && sv && run[i] == 0;
                run[i] = (sv != m_level[i]) ? run[i] + 1 : 0;
                if (run[i] == D + 1) begin
                    m_level[i] = sv;
                    m_press[i] = sv;
                    m_rel[i] = !sv;
                    run[i] = 0;
                    held_cnt[i] = 0;
                end else if (staying_held) begin
                    held_cnt[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    if (held_cnt[i] == RD || (held_cnt[i] > RD && (held_cnt[i] - RD) % RP == 0))
                        m_press[i] = 1'b1;
`endif
                end
            end
            for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = btn_raw;
        end
    end

    always @(negedge clk) begin
        check("model_level", btn_level, m_level);
        check("model_press", btn_press, m_press);
        check("model_release", btn_release, m_rel);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, pos_a;
        int hold [N];
        rst = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        check("reset_level", btn_level, 4'b0000);
        check("reset_press", btn_press, 4'b0000);
        check("reset_release", btn_release, 4'b0000);
        // clean press on channel 0: first sampling edge is the next posedge
        rst = 1'b0;
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            check("clean_press", btn_press, (i == 11) ? 4'b0001 : 4'b0000);
            check("clean_level", btn_level, (i >= 11) ? 4'b0001 : 4'b0000);
        end
        // bounce rejection on channel 1
        cnt_a = 0;
        for (int c = 0; c < 42; c++) begin
            btn_raw[1] = (c < 30) && ((c / 3) % 2 == 0);
            @(negedge clk);
            cnt_a += int'(btn_press[1]) + int'(btn_level[1]) + int'(btn_release[1]);
        end
        check_int("bounce_quiet", cnt_a, 0);
        // release with a one-cycle glitch on channel 2
        btn_raw[2] = 1'b1;
        pos_a = 0;
        for (int i = 0; i < 30 && !btn_level[2]; i++) @(negedge clk);
        check_int("glitch_level_up", int'(btn_level[2]), 1);
        btn_raw[2] = 1'b0;
        repeat (4) @(negedge clk);
        btn_raw[2] = 1'b1;
        @(negedge clk);
        btn_raw[2] = 1'b0;
        cnt_a = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (btn_release[2]) begin
                cnt_a++;
                pos_a = i;
            end
        end
        check_int("glitch_release_count", cnt_a, 1);
        check_int("glitch_release_pos", pos_a, 11);
        // simultaneous press on channels 0 and 3
        btn_raw[0] = 1'b0;
        repeat (14) @(negedge clk);
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            check("simul_press", btn_press & 4'b1001, (i == 11) ? 4'b1001 : 4'b0000);
        end
        // reset while both are held
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_level", btn_level, 4'b0000);
            check("rst_mid_press", btn_press, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            check("rst_repress", btn_press & 4'b1001, (i == 11) ? 4'b1001 : 4'b0000);
            check("rst_no_release", btn_release, 4'b0000);
        end
        // keep holding: pulses at +20..+50 from the press only with auto-repeat
        cnt_a = 0;
        for (int i = 1; i <= 52; i++) begin
            @(negedge clk);
            cnt_a += int'(btn_press[0]);
        end
`ifdef BTN_AUTOREPEAT_EN
        check_int("repeat_count", cnt_a, 7);
`else
        check_int("repeat_count", cnt_a, 0);
`endif
        btn_raw = '0;
        repeat (15) @(negedge clk);
        // random bursts of mixed short and long holds, with occasional resets
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(9, 40) : $urandom_range(0, 7);
                end else hold[i]--;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        btn_raw = '0;
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
